pong_serve_ctrl: RTL and testbench
==================================

PONG_SERVE_CTRL -- requirements
Module: pong_serve_ctrl

Interface
REQ-001 SHALL have parameter p_H_VISIBLE, default 640: visible line width in pixels.
REQ-002 SHALL have parameter p_BALL_SIZE, default 10: ball width in pixels.
REQ-003 SHALL have parameter p_SERVE_FRAMES, default 60: frames of pause before each serve.
REQ-004 SHALL have parameter p_WIN_SCORE, default 9: points that end a game.
REQ-005 SHALL have port i_Clk, input, 1 bit: pixel clock, the only clock; all logic on its rising edge.
REQ-006 SHALL have port i_Rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port i_VReset, input, 1 bit: one-cycle frame tick at the start of each frame.
REQ-008 SHALL have port i_Start, input, 1 bit: start button, level, already debounced.
REQ-009 SHALL have port i_HitL, input, 1 bit: left paddle/ball overlap pulse, any cycle.
REQ-010 SHALL have port i_HitR, input, 1 bit: right paddle/ball overlap pulse, any cycle.
REQ-011 SHALL have port o_XDir, output, 1 bit: ball direction to the ball block; 1 = left, 0 = right.
REQ-012 SHALL have port o_Run, output, 1 bit: ball motion enable; 1 only in PLAY.
REQ-013 SHALL have port o_PosX, output, 10 bits: shadow ball left-edge x, range 0..p_H_VISIBLE-p_BALL_SIZE.
REQ-014 SHALL have port o_ScoreL, output, 4 bits: left player score.
REQ-015 SHALL have port o_ScoreR, output, 4 bits: right player score.
REQ-016 SHALL have port o_State, output, 3 bits: FSM state code.

Function
REQ-017 SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.
REQ-018 SHALL detect i_Start rising edge with a registered previous sample; start pulse = i_Start & ~prev.
REQ-019 SHALL move IDLE->SERVE on start pulse, clearing both scores, o_PosX = (p_H_VISIBLE-p_BALL_SIZE)/2 (315), o_XDir = 1.
REQ-020 SHALL, in SERVE, hold o_PosX at centre and count frame ticks; on the p_SERVE_FRAMES-th tick move to PLAY, counter cleared.
REQ-021 SHALL latch i_HitL/i_HitR into sticky flags, consumed and cleared on each frame tick; a hit on the tick cycle is used for that tick and not retained.
REQ-022 SHALL, in PLAY on each frame tick with o_XDir=1: hitL flag -> o_XDir<=0, no move; else o_PosX==0 -> POINT, right scores; else o_PosX-=1.
REQ-023 SHALL, in PLAY on each frame tick with o_XDir=0: hitR flag -> o_XDir<=1, no move; else o_PosX==p_H_VISIBLE-p_BALL_SIZE -> POINT, left scores; else o_PosX+=1.
REQ-024 SHALL ignore the hit flag for the side opposite to o_XDir; both flags set -> only the side matching o_XDir applies.
REQ-025 SHALL, in POINT (one cycle), increment the scorer's score, set o_XDir toward the losing player, recentre o_PosX, go to SERVE, unless REQ-034 applies.
REQ-026 SHALL ignore frame ticks outside SERVE/PLAY and ignore start pulses outside IDLE/GAMEOVER.
REQ-027 SHALL, in GAMEOVER, hold scores and position; a start pulse behaves exactly as REQ-019.
REQ-028 SHALL update all outputs registered; o_Run = (state==PLAY), no combinational path from input to output.

Reset
REQ-029 SHALL, while i_Rst_n=0 at a clock edge, set state IDLE, o_Run=0, o_XDir=1, o_PosX=315, scores 0, serve counter 0, hit flags 0, start-edge register 0.
REQ-030 SHALL, on reset mid-game (any state), abandon the game entirely; no score or position survives.
REQ-031 SHALL not generate a start pulse from i_Start held high across reset release.

Configuration
REQ-032 SHALL support macro SCORE_LIMIT_EN.
REQ-033 SHALL, without SCORE_LIMIT_EN, never enter GAMEOVER; a score of 15 increments to 0 (4-bit wrap), play continues.
REQ-034 SHALL, with SCORE_LIMIT_EN, go POINT->GAMEOVER when the incremented score equals p_WIN_SCORE; o_Run=0 thereafter.

Verification (bench: p_H_VISIBLE=40, p_BALL_SIZE=10, p_SERVE_FRAMES=3, p_WIN_SCORE=2)
REQ-035 SHALL cover: reset, start pulse, 3 frame ticks -> SERVE then PLAY after 3rd tick, o_PosX=15, o_XDir=1, o_Run=1.
REQ-036 SHALL cover: PLAY, no hits, 15 ticks -> o_PosX=0; 16th tick -> POINT, o_ScoreR=1, o_XDir=1 (toward left loser), o_PosX=15, SERVE.
REQ-037 SHALL cover: o_XDir=1, i_HitL pulse mid-frame -> next tick o_XDir=0, o_PosX unchanged; following tick o_PosX+1.
REQ-038 SHALL cover: o_XDir=1, i_HitR pulse -> ignored; i_HitL on tick cycle itself -> bounce that tick.
REQ-039 SHALL cover: SCORE_LIMIT_EN defined, right scores twice -> GAMEOVER, o_ScoreR=2, o_Run=0; start pulse -> scores 0, SERVE. Undefined: o_ScoreR=15 then point -> 0, SERVE.
REQ-040 SHALL cover: reset asserted in PLAY at o_PosX=20, o_ScoreL=1 -> next edge IDLE, o_PosX=315 value per REQ-029 formula (15 in bench), scores 0.

Source files
------------

// File: rtl/pong_serve_ctrl.sv
// Pong serve/score controller: owns the game FSM, shadow ball x position, direction and scores.
// All outputs registered (1-cycle latency from inputs); no backpressure. Optional macro SCORE_LIMIT_EN ends the game at p_WIN_SCORE.
module pong_serve_ctrl #(
    parameter int p_H_VISIBLE    = 640,
    parameter int p_BALL_SIZE    = 10,
    parameter int p_SERVE_FRAMES = 60,
    parameter int p_WIN_SCORE    = 9
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_VReset,
    input  logic       i_Start,
    input  logic       i_HitL,
    input  logic       i_HitR,
    output logic       o_XDir,
    output logic       o_Run,
    output logic [9:0] o_PosX,
    output logic [3:0] o_ScoreL,
    output logic [3:0] o_ScoreR,
    output logic [2:0] o_State
);

    localparam logic [9:0] C_CENTRE = 10'((p_H_VISIBLE - p_BALL_SIZE) / 2);
    localparam logic [9:0] C_XMAX   = 10'(p_H_VISIBLE - p_BALL_SIZE);
    localparam int         C_CW     = $clog2(p_SERVE_FRAMES + 1);
    localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(p_SERVE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SERVE    = 3'd1,
        S_PLAY     = 3'd2,
        S_POINT    = 3'd3,
        S_GAMEOVER = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              run_q, run_d;
    logic              xdir_q, xdir_d;
    logic [9:0]        posx_q, posx_d;
    logic [3:0]        score_l_q, score_l_d;
    logic [3:0]        score_r_q, score_r_d;
    logic [C_CW-1:0]   cnt_q, cnt_d;
    logic              hit_l_q, hit_l_d;
    logic              hit_r_q, hit_r_d;
    logic              scorer_r_q, scorer_r_d;
    logic              start_prev_q;
    logic              arm_q;

    logic              start_pulse;
    logic              hit_l_eff;
    logic              hit_r_eff;
    logic [3:0]        score_inc;
    logic              game_won;

    // arm_q masks the first cycle after reset so a start held across release is not an edge
    assign start_pulse = i_Start & ~start_prev_q & arm_q;
    assign hit_l_eff   = hit_l_q | i_HitL;
    assign hit_r_eff   = hit_r_q | i_HitR;
    assign score_inc   = (scorer_r_q ? score_r_q : score_l_q) + 4'd1;

`ifdef SCORE_LIMIT_EN
    assign game_won = (score_inc == 4'(p_WIN_SCORE));
`else
    assign game_won = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        xdir_d     = xdir_q;
        posx_d     = posx_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        cnt_d      = cnt_q;
        scorer_r_d = scorer_r_q;
        hit_l_d    = i_VReset ? 1'b0 : hit_l_eff;
        hit_r_d    = i_VReset ? 1'b0 : hit_r_eff;

        case (state_q)
            S_IDLE, S_GAMEOVER: begin
                if (start_pulse) begin
                    state_d   = S_SERVE;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    posx_d    = C_CENTRE;
                    xdir_d    = 1'b1;
                    cnt_d     = '0;
                end
            end
            S_SERVE: begin
                posx_d = C_CENTRE;
                if (i_VReset) begin
                    if (cnt_q == C_CNT_LAST) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (i_VReset) begin
                    if (xdir_q) begin
                        if (hit_l_eff) begin
                            xdir_d = 1'b0;
                        end else if (posx_q == 10'd0) begin
                            state_d    = S_POINT;
                            scorer_r_d = 1'b1;
                        end else begin
                            posx_d = posx_q - 10'd1;
                        end
                    end else begin
                        if (hit_r_eff) begin
                            xdir_d = 1'b1;
                        end else if (posx_q == C_XMAX) begin
                            state_d    = S_POINT;
                            scorer_r_d = 1'b0;
                        end else begin
                            posx_d = posx_q + 10'd1;
                        end
                    end
                end
            end
            S_POINT: begin
                if (scorer_r_q) begin
                    score_r_d = score_inc;
                end else begin
                    score_l_d = score_inc;
                end
                if (game_won) begin
                    state_d = S_GAMEOVER;
                end else begin
                    // serve toward the player who just lost the point
                    xdir_d  = scorer_r_q;
                    posx_d  = C_CENTRE;
                    state_d = S_SERVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        run_d = (state_d == S_PLAY);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q      <= S_IDLE;
            run_q        <= 1'b0;
            xdir_q       <= 1'b1;
            posx_q       <= C_CENTRE;
            score_l_q    <= 4'd0;
            score_r_q    <= 4'd0;
            cnt_q        <= '0;
            hit_l_q      <= 1'b0;
            hit_r_q      <= 1'b0;
            scorer_r_q   <= 1'b0;
            start_prev_q <= 1'b0;
            arm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            xdir_q       <= xdir_d;
            posx_q       <= posx_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            cnt_q        <= cnt_d;
            hit_l_q      <= hit_l_d;
            hit_r_q      <= hit_r_d;
            scorer_r_q   <= scorer_r_d;
            start_prev_q <= i_Start;
            arm_q        <= 1'b1;
        end
    end

    assign o_State  = state_q;
    assign o_Run    = run_q;
    assign o_XDir   = xdir_q;
    assign o_PosX   = posx_q;
    assign o_ScoreL = score_l_q;
    assign o_ScoreR = score_r_q;

endmodule

// File: tb/tb_pong_serve_ctrl.sv
// Randomized and directed bench for pong_serve_ctrl against a rule-level game model.
module tb_pong_serve_ctrl;

    localparam int HV = 40;
    localparam int BS = 10;
    localparam int SF = 3;
    localparam int WS = 2;
    localparam int CTR  = (HV - BS) / 2;
    localparam int XMAX = HV - BS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vr = 1'b0;
    logic       st = 1'b0;
    logic       hl = 1'b0;
    logic       hr = 1'b0;
    logic       xdir, run;
    logic [9:0] posx;
    logic [3:0] score_l, score_r;
    logic [2:0] state;

    pong_serve_ctrl #(
        .p_H_VISIBLE(HV), .p_BALL_SIZE(BS), .p_SERVE_FRAMES(SF), .p_WIN_SCORE(WS)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_VReset(vr), .i_Start(st),
        .i_HitL(hl), .i_HitR(hr), .o_XDir(xdir), .o_Run(run), .o_PosX(posx),
        .o_ScoreL(score_l), .o_ScoreR(score_r), .o_State(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // game model: phase names are bench-side, values follow the published state codes
    int m_phase, m_x, m_dir, m_sl, m_sr, m_frames;
    bit m_pendl, m_pendr, m_last_start, m_live, m_right_scored;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_x = CTR; m_dir = 1; m_sl = 0; m_sr = 0; m_frames = 0;
        m_pendl = 0; m_pendr = 0; m_last_start = 0; m_live = 0; m_right_scored = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit v, input bit l, input bit h);
        bit pressed, lhit, rhit;
        if (!r) begin
            model_reset();
            return;
        end
        pressed = s && !m_last_start && m_live;
        m_last_start = s;
        m_live = 1;
        lhit = m_pendl || l;
        rhit = m_pendr || h;
        m_pendl = v ? 1'b0 : lhit;
        m_pendr = v ? 1'b0 : rhit;
        if (m_phase == 0 || m_phase == 4) begin
            if (pressed) begin
                m_phase = 1; m_sl = 0; m_sr = 0; m_x = CTR; m_dir = 1; m_frames = 0;
            end
        end else if (m_phase == 1) begin
            m_x = CTR;
            if (v) begin
                m_frames++;
                if (m_frames >= SF) begin
                    m_phase = 2;
                    m_frames = 0;
                end
            end
        end else if (m_phase == 2) begin
            if (v) begin
                if (m_dir == 1 && lhit) m_dir = 0;
                else if (m_dir == 0 && rhit) m_dir = 1;
                else if (m_dir == 1 && m_x == 0) begin m_phase = 3; m_right_scored = 1; end
                else if (m_dir == 0 && m_x == XMAX) begin m_phase = 3; m_right_scored = 0; end
                else m_x = m_x + (m_dir == 1 ? -1 : 1);
            end
        end else if (m_phase == 3) begin
            int ns;
            ns = ((m_right_scored ? m_sr : m_sl) + 1) % 16;
            if (m_right_scored) m_sr = ns; else m_sl = ns;
`ifdef SCORE_LIMIT_EN
            if (ns == WS) m_phase = 4;
            else begin m_phase = 1; m_x = CTR; m_dir = m_right_scored ? 1 : 0; end
`else
            m_phase = 1; m_x = CTR; m_dir = m_right_scored ? 1 : 0;
`endif
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit v, input bit l, input bit h);
        rst_n = r; st = s; vr = v; hl = l; hr = h;
        @(posedge clk);
        model_step(r, s, v, l, h);
        #1;
        chk("state", 32'(state), 32'(m_phase));
        chk("posx", 32'(posx), 32'(m_x));
        chk("xdir", 32'(xdir), 32'(m_dir));
        chk("run", 32'(run), 32'(m_phase == 2));
        chk("score_l", 32'(score_l), 32'(m_sl));
        chk("score_r", 32'(score_r), 32'(m_sr));
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0);
    endtask

    task automatic tick_only();
        cyc(1, 0, 1, 0, 0);
    endtask

    task automatic tick();
        tick_only();
        idle();
    endtask

    task automatic press();
        cyc(1, 1, 0, 0, 0);
        idle();
    endtask

    task automatic right_point();
        for (int i = 0; i < SF; i++) tick();
        for (int i = 0; i < CTR + 1; i++) tick();
    endtask

    initial begin
        model_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_posx", 32'(posx), CTR);
        chk("rst_xdir", 32'(xdir), 1);
        chk("rst_run", 32'(run), 0);
        chk("rst_scores", 32'({score_l, score_r}), 0);
        idle();
        press();
        chk("start_serve", 32'(state), 1);
        tick(); tick();
        chk("serve_hold", 32'(state), 1);
        tick();
        chk("play_state", 32'(state), 2);
        chk("play_posx", 32'(posx), CTR);
        chk("play_run", 32'(run), 1);
        for (int i = 0; i < CTR; i++) tick();
        chk("edge_posx0", 32'(posx), 0);
        tick_only();
        chk("point_state", 32'(state), 3);
        idle();
        chk("after_point_state", 32'(state), 1);
        chk("after_point_sr", 32'(score_r), 1);
        chk("after_point_dir", 32'(xdir), 1);
        chk("after_point_posx", 32'(posx), CTR);
        for (int i = 0; i < SF; i++) tick();
        cyc(1, 0, 0, 1, 0);
        idle();
        tick_only();
        chk("bounce_l_dir", 32'(xdir), 0);
        chk("bounce_l_posx", 32'(posx), CTR);
        idle();
        tick_only();
        chk("after_bounce_posx", 32'(posx), CTR + 1);
        cyc(1, 0, 0, 1, 0);
        tick_only();
        chk("ignore_l_posx", 32'(posx), CTR + 2);
        cyc(1, 0, 1, 0, 1);
        chk("tick_hit_r_dir", 32'(xdir), 1);
        idle();
        cyc(1, 0, 0, 0, 1);
        tick_only();
        chk("ignore_r_posx", 32'(posx), CTR + 1);
        cyc(1, 0, 1, 1, 0);
        chk("tick_hit_l_dir", 32'(xdir), 0);
        chk("tick_hit_l_posx", 32'(posx), CTR + 1);
        idle();
        for (int i = 0; i < XMAX - CTR - 1; i++) tick();
        chk("edge_posxmax", 32'(posx), XMAX);
        tick_only();
        idle();
        chk("left_point_sl", 32'(score_l), 1);
        chk("left_point_dir", 32'(xdir), 0);
        for (int i = 0; i < SF + 5; i++) tick();
        chk("pre_rst_posx", 32'(posx), 20);
        cyc(0, 0, 0, 0, 0);
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_posx", 32'(posx), CTR);
        chk("mid_rst_sl", 32'(score_l), 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("held_start_idle", 32'(state), 0);
        idle();
        press();
`ifdef SCORE_LIMIT_EN
        right_point();
        right_point();
        chk("gameover_state", 32'(state), 4);
        chk("gameover_sr", 32'(score_r), WS);
        chk("gameover_run", 32'(run), 0);
        tick();
        chk("gameover_hold", 32'(state), 4);
        press();
        chk("restart_state", 32'(state), 1);
        chk("restart_sr", 32'(score_r), 0);
`else
        for (int i = 0; i < 15; i++) right_point();
        chk("sr_15", 32'(score_r), 15);
        right_point();
        chk("sr_wrap", 32'(score_r), 0);
        chk("wrap_state", 32'(state), 1);
`endif
        for (int i = 0; i < 5000; i++) begin
            bit r, s, v, l, h;
            r = ($urandom_range(0, 399) != 0);
            s = ($urandom_range(0, 19) == 0) ? ~st : st;
            v = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 9) == 0);
            h = ($urandom_range(0, 9) == 0);
            cyc(r, s, v, l, h);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
